data_mem_responder: RTL and testbench

- Data-memory responder for the RV64I core: the far end of the datapath's MemRead/MemWrite load/store interface.
- Accepts one doubleword (ld/sd) request at a time over a valid/ready handshake.
- Services the request after a fixed, parameterized latency and returns read data or an error on a valid/ready response channel.
- Sits between the core's memory stage and a behavioural/SRAM doubleword array.

---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/data_mem_responder_if.sv | 27 ++
 rtl/data_mem_responder_mem_array.sv | 25 ++
 rtl/data_mem_responder.sv | 120 ++++++++++++
 tb/tb_data_mem_responder.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the doubleword data-memory responder.
// Holds the FSM state encoding and the access-legality rule used by the responder.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

    localparam int DWORD_W           = 64;
    localparam int DWORD_OFFSET_BITS = 3;

    // Misaligned or beyond the last doubleword; the address is treated as unsigned.
    function automatic logic addr_err(input logic [DWORD_W-1:0] addr, input int unsigned depth);
        return (addr[DWORD_OFFSET_BITS-1:0] != '0) ||
               ((addr >> DWORD_OFFSET_BITS) >= 64'(depth));
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core memory stage and the responder.
// The master modport is the core side, the slave modport is the responder side.
interface data_mem_responder_if
    import mem_pkg::*;
();

    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [DWORD_W-1:0] req_addr;
    logic [DWORD_W-1:0] req_wdata;
    logic               resp_valid;
    logic               resp_ready;
    logic [DWORD_W-1:0] resp_rdata;
    logic               resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_responder_mem_array.sv
// Single-port doubleword array: synchronous write, registered read-first output.
// Contents are never reset so the array maps onto block RAM.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   idx,
    input  logic [DWORD_W-1:0] wdata,
    output logic [DWORD_W-1:0] rdata
);

    logic [DWORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
        rdata <= r_mem[idx];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency ld/sd responder: one outstanding request, array access on the edge entering RESP,
// response held until the core accepts it.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    mem_state_t         r_state;
    mem_state_t         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_write;
    logic               r_err;
    logic [DWORD_W-1:0] r_addr;
    logic [DWORD_W-1:0] r_wdata;

    logic               w_accept;
    logic               w_enter_resp;
    logic               w_sel_write;
    logic               w_sel_err;
    logic               w_we;
    logic [DWORD_W-1:0] w_sel_addr;
    logic [DWORD_W-1:0] w_sel_wdata;
    logic [DWORD_W-1:0] w_mem_rdata;
    logic [IDX_W-1:0]   w_idx;

    assign bus.req_ready = (r_state == IDLE) && !reset;
    assign w_accept      = bus.req_valid && bus.req_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);

    // Entering RESP straight from IDLE only happens when LATENCY==1; the request fields are
    // not latched yet on that edge, so the access uses them live.
    assign w_sel_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
    assign w_sel_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;
    assign w_sel_write = (r_state == IDLE) ? bus.req_write : r_write;
    assign w_sel_err   = addr_err(w_sel_addr, DEPTH);
    assign w_idx       = w_sel_addr[IDX_W+DWORD_OFFSET_BITS-1:DWORD_OFFSET_BITS];
    assign w_we        = w_enter_resp && w_sel_write && !w_sel_err;

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (w_we),
        .idx   (w_idx),
        .wdata (w_sel_wdata),
        .rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (w_enter_resp) begin
                r_err <= w_sel_err;
            end else if ((r_state == RESP) && bus.resp_ready) begin
                r_err <= 1'b0;
            end
        end
    end

    // The array output register keeps re-reading the held index, so load data stays stable in RESP.
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_err   = (r_state == RESP) && r_err;
    assign bus.resp_rdata = ((r_state == RESP) && !r_write && !r_err) ? w_mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances (LATENCY 2, 4, 1) driven by
// directed vectors, corner-case sequences and random traffic against a doubleword array model.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int N     = 3;
    localparam int DEPTH = 256;
    localparam int LATS[N] = '{2, 4, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [N];
    logic        req_write [N];
    logic        resp_ready[N];
    logic        req_ready [N];
    logic        resp_valid[N];
    logic        resp_err  [N];
    logic [63:0] req_addr  [N];
    logic [63:0] req_wdata [N];
    logic [63:0] resp_rdata[N];

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mdl  [N][DEPTH];
    bit          known[N][DEPTH];

    typedef struct {
        int          k;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            data_mem_responder_if bus ();
            assign bus.req_valid  = req_valid[gi];
            assign bus.req_write  = req_write[gi];
            assign bus.req_addr   = req_addr[gi];
            assign bus.req_wdata  = req_wdata[gi];
            assign bus.resp_ready = resp_ready[gi];
            assign req_ready[gi]  = bus.req_ready;
            assign resp_valid[gi] = bus.resp_valid;
            assign resp_rdata[gi] = bus.resp_rdata;
            assign resp_err[gi]   = bus.resp_err;

            data_mem_responder #(
                .DEPTH   (DEPTH),
                .LATENCY (LATS[gi])
            ) u_dut (
                .clk   (clk),
                .reset (rst),
                .bus   (bus.slave)
            );
        end
    endgenerate

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, k, act, exp);
        end
    endtask

    function automatic bit exp_err(input logic [63:0] a);
        return ((a % 64'd8) != 64'd0) || ((a / 64'd8) >= 64'(DEPTH));
    endfunction

    // One request/response; hold>0 keeps resp_ready low that many cycles (with a stray request pulse).
    task automatic txn(input int k, input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                       input int hold, output logic [63:0] rd, output logic er);
        int lat;
        @(negedge clk);
        req_write[k]  = wr;
        req_addr[k]   = addr;
        req_wdata[k]  = wd;
        req_valid[k]  = 1'b1;
        resp_ready[k] = (hold == 0);
        for (int i = 0; i < 20 && !req_ready[k]; i++) @(negedge clk);
        chk("req_ready_idle", k, 64'(req_ready[k]), 64'd1);
        @(negedge clk);
        lat = 1;
        req_valid[k] = 1'b0;
        req_write[k] = ~wr;
        req_addr[k]  = ~addr;
        req_wdata[k] = ~wd;
        chk("req_ready_busy", k, 64'(req_ready[k]), 64'd0);
        while (!resp_valid[k] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", k, 64'(lat), 64'(LATS[k]));
        rd = resp_rdata[k];
        er = resp_err[k];
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                req_valid[k] = 1'b1;
                req_write[k] = 1'b1;
                req_addr[k]  = addr;
                req_wdata[k] = 64'hBAD0_BAD0_BAD0_BAD0;
            end else if (h == 2) begin
                req_valid[k] = 1'b0;
            end
            @(negedge clk);
            chk("hold_valid", k, 64'(resp_valid[k]), 64'd1);
            chk("hold_rdata", k, resp_rdata[k], rd);
            chk("hold_err", k, 64'(resp_err[k]), 64'(er));
            chk("hold_req_ready", k, 64'(req_ready[k]), 64'd0);
        end
        req_valid[k]  = 1'b0;
        resp_ready[k] = 1'b1;
        @(negedge clk);
        chk("post_valid", k, 64'(resp_valid[k]), 64'd0);
        chk("post_rdata", k, resp_rdata[k], 64'd0);
        chk("post_err", k, 64'(resp_err[k]), 64'd0);
        chk("post_req_ready", k, 64'(req_ready[k]), 64'd1);
        resp_ready[k] = 1'b0;
        $display("txn dut%0d L=%0d %s addr=0x%h wdata=0x%h -> rdata=0x%h err=%0d lat=%0d hold=%0d",
                 k, LATS[k], wr ? "sd" : "ld", addr, wd, rd, er, lat, hold);
    endtask

    task automatic model_txn(input int k, input bit wr, input logic [63:0] addr,
                             input logic [63:0] wd, input int hold);
        logic [63:0] rd;
        logic        er;
        bit          e;
        int          idx;
        txn(k, wr, addr, wd, hold, rd, er);
        e = exp_err(addr);
        idx = e ? 0 : int'(addr / 64'd8);
        chk("resp_err", k, 64'(er), 64'(e));
        if (wr || e) begin
            chk("resp_rdata_zero", k, rd, 64'd0);
        end else if (known[k][idx]) begin
            chk("load_data", k, rd, mdl[k][idx]);
        end
        if (wr && !e) begin
            mdl[k][idx]   = wd;
            known[k][idx] = 1'b1;
        end
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        logic [63:0] a;
        int          sel;

        vecs[0]  = '{0, 1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0};
        vecs[1]  = '{0, 1'b0, 64'h10,  64'h0,                 64'hDEADBEEF_CAFEF00D, 1'b0};
        vecs[2]  = '{0, 1'b1, 64'h13,  64'h1234_5678,         64'h0, 1'b1};
        vecs[3]  = '{0, 1'b0, 64'h10,  64'h0,                 64'hDEADBEEF_CAFEF00D, 1'b0};
        vecs[4]  = '{0, 1'b0, 64'h800, 64'h0,                 64'h0, 1'b1};
        vecs[5]  = '{0, 1'b1, 64'h7F8, 64'hA5A5_0000_5A5A,    64'h0, 1'b0};
        vecs[6]  = '{0, 1'b0, 64'h7F8, 64'h0,                 64'hA5A5_0000_5A5A, 1'b0};
        vecs[7]  = '{0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 1'b1};
        vecs[8]  = '{0, 1'b1, 64'h0,   64'h77,                64'h0, 1'b0};
        vecs[9]  = '{0, 1'b1, 64'h800, 64'h99,                64'h0, 1'b1};
        vecs[10] = '{0, 1'b0, 64'h0,   64'h0,                 64'h77, 1'b0};
        vecs[11] = '{1, 1'b1, 64'h20,  64'h5555,              64'h0, 1'b0};
        vecs[12] = '{2, 1'b1, 64'h40,  64'hC0FF_EE00_1234_ABCD, 64'h0, 1'b0};

        for (int k = 0; k < N; k++) begin
            req_valid[k]  = 1'b0;
            req_write[k]  = 1'b0;
            req_addr[k]   = '0;
            req_wdata[k]  = '0;
            resp_ready[k] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_req_ready", k, 64'(req_ready[k]), 64'd0);
            chk("rst_resp_valid", k, 64'(resp_valid[k]), 64'd0);
            chk("rst_resp_rdata", k, resp_rdata[k], 64'd0);
            chk("rst_resp_err", k, 64'(resp_err[k]), 64'd0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) chk("rel_req_ready", k, 64'(req_ready[k]), 64'd1);

        // Directed vectors
        for (int v = 0; v < 13; v++) begin
            txn(vecs[v].k, vecs[v].wr, vecs[v].addr, vecs[v].wdata, 0, rd, er);
            chk($sformatf("vec%0d_rdata", v), vecs[v].k, rd, vecs[v].exp_rd);
            chk($sformatf("vec%0d_err", v), vecs[v].k, 64'(er), 64'(vecs[v].exp_err));
            if (vecs[v].wr && !vecs[v].exp_err) begin
                mdl[vecs[v].k][int'(vecs[v].addr / 64'd8)]   = vecs[v].wdata;
                known[vecs[v].k][int'(vecs[v].addr / 64'd8)] = 1'b1;
            end
        end

        // Stalled response with a stray request pulse, then confirm the array is untouched
        model_txn(0, 1'b0, 64'h10, 64'h0, 5);
        model_txn(0, 1'b0, 64'h10, 64'h0, 0);

        // LATENCY=4: reset while the store is still waiting must discard it
        @(negedge clk);
        req_write[1]  = 1'b1;
        req_addr[1]   = 64'h20;
        req_wdata[1]  = 64'h1111;
        req_valid[1]  = 1'b1;
        resp_ready[1] = 1'b1;
        chk("l4_req_ready", 1, 64'(req_ready[1]), 64'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("l4_wait_valid", 1, 64'(resp_valid[1]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("l4_rst_ready", 1, 64'(req_ready[1]), 64'd0);
        chk("l4_rst_valid", 1, 64'(resp_valid[1]), 64'd0);
        @(negedge clk);
        chk("l4_rst_ready2", 1, 64'(req_ready[1]), 64'd0);
        rst = 1'b0;
        #1;
        chk("l4_rel_ready", 1, 64'(req_ready[1]), 64'd1);
        @(negedge clk);
        chk("l4_rel_valid", 1, 64'(resp_valid[1]), 64'd0);
        chk("l4_rel_ready2", 1, 64'(req_ready[1]), 64'd1);
        resp_ready[1] = 1'b0;
        model_txn(1, 1'b0, 64'h20, 64'h0, 0);

        // LATENCY=1 back-to-back loads: one response every other cycle
        @(negedge clk);
        req_write[2]  = 1'b0;
        req_addr[2]   = 64'h40;
        req_valid[2]  = 1'b1;
        resp_ready[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("b2b%0d_valid", i), 2, 64'(resp_valid[2]), 64'(i % 2));
            chk($sformatf("b2b%0d_ready", i), 2, 64'(req_ready[2]), 64'((i + 1) % 2));
            if (i % 2 == 1) chk($sformatf("b2b%0d_rdata", i), 2, resp_rdata[2], mdl[2][8]);
        end
        $display("txn dut2 L=1 back-to-back ld addr=0x40 x4 rdata=0x%h", mdl[2][8]);
        req_valid[2] = 1'b0;
        @(negedge clk);
        resp_ready[2] = 1'b0;

        // Random traffic against the array model
        for (int t = 0; t < 150; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                a = 64'($urandom_range(0, 31)) * 64'd8 + 64'($urandom_range(1, 7));
            end else if (sel == 1) begin
                a = {$urandom, $urandom} & ~64'h7;
                if (a < 64'(DEPTH * 8)) a = 64'(DEPTH * 8) + a;
            end else begin
                a = 64'($urandom_range(0, 31)) * 64'd8;
            end
            model_txn(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), a,
                      {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
